uart_frame_loader: RTL and testbench



---
 rtl/uart_frame_loader.sv | 187 ++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// UART receiver that packs BYTES_PER_PIX bytes per pixel and writes them linearly into a frame buffer.
// Optional even parity bit when UART_FRAME_LOADER_PARITY_EN is defined (8E1); otherwise 8N1.
module uart_frame_loader #(
    parameter int BAUD_CNT_END  = 434,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = 16,
    parameter int H_PIX         = 200,
    parameter int V_PIX         = 200,
    parameter int ADDR_W        = 16,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              byte_err
);
    localparam int BW   = (BAUD_CNT_END > 2) ? $clog2(BAUD_CNT_END) : 1;
    localparam int TW   = $clog2(TIMEOUT_BITS + 1);
    localparam int IW   = $clog2(BYTES_PER_PIX + 1);
    localparam int PK_W = BYTES_PER_PIX * 8;

    localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_CNT_END - 1);
    localparam logic [BW-1:0]     BAUD_HALF = BW'(BAUD_CNT_END / 2);
    localparam logic [TW-1:0]     TMO_MAX   = TW'(TIMEOUT_BITS);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(BYTES_PER_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_PIX * V_PIX - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        rx_sync;
    logic              rx_d;
    logic              rx_q;
    logic              fall;
    logic [BW-1:0]     baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_byte;
    logic [IW-1:0]     byte_idx;
    logic [PK_W-1:0]   pix_sr;
    logic [PK_W-1:0]   pix_nxt;
    logic [BW-1:0]     idle_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              par_bad;
    logic              bit_tick, mid_tick;
    logic              baud_clr, shift_bit, par_smp, stop_smp;
    logic              accept, bad_byte;

    assign rx_q     = rx_sync[1];
    assign fall     = rx_d & ~rx_q;
    assign bit_tick = (baud_cnt == BAUD_LAST);
    assign mid_tick = (baud_cnt == BAUD_HALF);
    assign accept   = stop_smp & rx_q & ~par_bad;
    assign bad_byte = stop_smp & ~(rx_q & ~par_bad);
    assign pix_nxt  = PK_W'({pix_sr, rx_byte});

    always_ff @(posedge sclk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_d    <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_d    <= rx_q;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        baud_clr  = 1'b0;
        shift_bit = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                baud_clr = 1'b1;
                if (fall) state_nxt = START;
            end
            START: begin
                // Re-check the line mid start bit; a short low pulse is treated as noise.
                if (mid_tick) begin
                    baud_clr  = 1'b1;
                    state_nxt = rx_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_bit = 1'b1;
`ifdef UART_FRAME_LOADER_PARITY_EN
                    if (bit_cnt == 3'd7) state_nxt = PAR;
`else
                    if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef UART_FRAME_LOADER_PARITY_EN
            PAR: begin
                if (bit_tick) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so the next start edge is never missed.
                if (bit_tick) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
        end else begin
            if (baud_clr || bit_tick) baud_cnt <= '0;
            else                      baud_cnt <= baud_cnt + 1'b1;
            if (state == START)  bit_cnt <= '0;
            else if (shift_bit)  bit_cnt <= bit_cnt + 1'b1;
            if (shift_bit) rx_byte <= {rx_q, rx_byte[7:1]};
        end
    end

`ifdef UART_FRAME_LOADER_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge sclk) begin
        if (rst)          par_bad <= 1'b0;
        else if (par_smp) par_bad <= ^{rx_byte, rx_q};
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (rst || state != IDLE || fall) begin
            idle_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (idle_cnt == BAUD_LAST) begin
            idle_cnt <= '0;
            if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            byte_idx   <= '0;
            pix_sr     <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            byte_err   <= bad_byte;
            if (wr_en) wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
            if (accept) begin
                pix_sr <= pix_nxt;
                if (byte_idx == IDX_LAST) begin
                    byte_idx   <= '0;
                    wr_en      <= 1'b1;
                    wr_data    <= PIX_W'(pix_nxt);
                    frame_done <= (wr_addr == ADDR_LAST);
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end else if (state == IDLE && tmo_cnt == TMO_MAX && byte_idx != '0) begin
                byte_idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized scoreboard bench for uart_frame_loader: a byte-level model predicts pixel writes and errors.
module tb_uart_frame_loader;
    localparam int BAUD = 8;
    localparam int BPP  = 2;
    localparam int HP   = 2;
    localparam int VP   = 2;
    localparam int TMO  = 4;
    localparam int NPIX = HP * VP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        wr_en, frame_done, byte_err;
    logic [15:0] wr_addr, wr_data;

    uart_frame_loader #(
        .BAUD_CNT_END(BAUD), .BYTES_PER_PIX(BPP), .PIX_W(16),
        .H_PIX(HP), .V_PIX(VP), .ADDR_W(16), .TIMEOUT_BITS(TMO)
    ) dut (
        .sclk(clk), .rst(rst), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .byte_err(byte_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   err_exp = 0;
    int   checks  = 0;
    int   errors  = 0;

    // Reference model state: bytes received toward the current pixel, next address.
    logic [7:0] part[$];
    int         m_addr = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        exp_t e;
        logic [15:0] pix;
        if (!ok) begin
            err_exp++;
            return;
        end
        part.push_back(b);
        if (part.size() == BPP) begin
            pix = 16'd0;
            foreach (part[i]) pix = (pix << 8) | 16'(part[i]);
            e.addr = m_addr;
            e.data = pix;
            e.done = (m_addr == NPIX - 1);
            exp_q.push_back(e);
            m_addr = (m_addr + 1) % NPIX;
            part.delete();
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BAUD) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input bit par_good);
        bit ok;
        ok = stop_bit;
`ifdef UART_FRAME_LOADER_PARITY_EN
        ok = ok && par_good;
`endif
        model_byte(b, ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_FRAME_LOADER_PARITY_EN
        drive_bit(par_good ? ^b : ~^b);
`endif
        drive_bit(stop_bit);
        // A low stop bit needs the line to go high again before the next start edge.
        if (!stop_bit) drive_bit(1'b1);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BAUD) @(posedge clk);
        if (bits > TMO) part.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_byte_err"}, byte_err, 0);
    endtask

    // Monitor: every strobe from the DUT is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && byte_err) check("err_with_wr", 1, 0);
            if (frame_done && !wr_en) check("done_without_wr", 1, 0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", wr_data, 0);
                    if (wr_data == 0) begin
                        errors++;
                        $display("FAIL unexpected_wr: got write at addr %0h expected none", wr_addr);
                    end
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("frame_done", frame_done, e.done);
                end
            end
            if (byte_err) begin
                check("byte_err_expected", (err_exp > 0), 1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Two pixels back to back.
        send(8'h12, 1, 1); send(8'h34, 1, 1); send(8'hAB, 1, 1); send(8'hCD, 1, 1);
        idle(6);
        // Fill the rest of the frame and wrap.
        for (int i = 1; i <= 8; i++) send(8'(i), 1, 1);
        send(8'hE1, 1, 1); send(8'hE2, 1, 1);
        idle(6);
        // Glitch rejection.
        rx = 1'b0; repeat (2) @(posedge clk); rx = 1'b1;
        idle(3);
        send(8'h55, 1, 1); send(8'h66, 1, 1);
        idle(6);
        // Partial pixel timeout.
        send(8'h12, 1, 1);
        idle(5);
        send(8'h34, 1, 1); send(8'h56, 1, 1);
        idle(6);
        // Framing error drops the byte.
        send(8'h77, 0, 1);
        send(8'h11, 1, 1); send(8'h22, 1, 1);
        idle(6);
`ifdef UART_FRAME_LOADER_PARITY_EN
        send(8'h03, 1, 1); send(8'h03, 1, 0); send(8'h04, 1, 1);
        idle(6);
`endif
        // Reset mid-pixel and mid-byte.
        send(8'h9A, 1, 1);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("mid_reset");
        part.delete();
        m_addr = 0;
        rst = 1'b0;
        idle(2);
        send(8'hC3, 1, 1); send(8'h3C, 1, 1);
        idle(6);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            logic [7:0] b;
            int r;
            b = 8'($urandom);
            r = $urandom_range(0, 15);
            send(b, (r != 0), (r != 1));
            if ($urandom_range(0, 7) == 0) idle(TMO + 2);
        end
        idle(6);

        check("pending_writes", exp_q.size(), 0);
        check("pending_errors", err_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
